fir_coef_seq_ctrl: RTL
======================

// Module: fir_coef_seq_ctrl
// PURPOSE
//  Sequencer in front of a DW_fir instance (ORDER taps). It collects a coefficient set from a
//  config port, waits for the filter to drain, and shifts the set into the filter (coef_shift_en).
//  It then flushes the delay line and streams samples with a valid/ready input and a valid-tagged
//  output. Sits between the host config/sample interfaces and the DW_fir instance.
// PARAMETERS
//  DATA_IN_W   8   sample width (DW_fir data_in_width)
//  COEF_W      8   coefficient width (DW_fir coef_width)
//  DATA_OUT_W  18  filter output width (DW_fir data_out_width)
//  ORDER       6   tap count, >=2 (DW_fir order)
//  FIR_LAT     1   cycles from fir_data_in sampled to fir_data_out valid, >=1
//  TC          1   two's-complement mode driven on fir_tc (constant)
// PORTS
//  clk              in   1           clock, all logic rising-edge
//  rst              in   1           synchronous reset, active-high
//  cfg_valid        in   1           coefficient word offered
//  cfg_ready        out  1           coefficient word accepted when cfg_valid&&cfg_ready
//  cfg_coef         in   COEF_W      coefficient, written in DW_fir shift-in order
//  s_valid          in   1           input sample offered
//  s_ready          out  1           sample accepted when s_valid&&s_ready
//  s_data           in   DATA_IN_W   input sample
//  m_valid          out  1           m_data holds the filter output for an accepted sample
//  m_data           out  DATA_OUT_W  filter output (registered copy of fir_data_out)
//  busy             out  1           1 in any state except RUN
//  fir_coef_shift_en out 1           to DW_fir coef_shift_en
//  fir_coef_in      out  COEF_W      to DW_fir coef_in
//  fir_tc           out  1           to DW_fir tc (= TC)
//  fir_data_in      out  DATA_IN_W   to DW_fir data_in
//  fir_init_acc_val out  DATA_OUT_W  to DW_fir init_acc_val, constant 0
//  fir_data_out     in   DATA_OUT_W  from DW_fir data_out
// BEHAVIOUR
//  Reset: state=COLLECT, coef_cnt=0, vpipe=0. Outputs: cfg_ready=1, s_ready=0, m_valid=0, m_data=0,
//   busy=1, fir_coef_shift_en=0, fir_coef_in=0, fir_data_in=0. Reset mid-operation aborts any state.
//   The partial coefficient set is discarded. In-flight outputs are dropped (m_valid=0 next cycle).
//  FSM: COLLECT -> WAIT_DRAIN -> SHIFT -> FLUSH -> RUN; RUN -> COLLECT on first cfg_valid.
//  COLLECT: cfg_ready=1. Each handshake writes buf[coef_cnt] and increments coef_cnt.
//   On handshake with coef_cnt==ORDER-1: coef_cnt<=0, cfg_ready<=0, go WAIT_DRAIN.
//  WAIT_DRAIN: cfg_ready=0. Stay until vpipe==0, then go SHIFT (same cycle check, no extra delay).
//  SHIFT: exactly ORDER cycles. fir_coef_shift_en=1, fir_coef_in=buf[i] in cycle i (i=0..ORDER-1).
//  FLUSH: exactly ORDER cycles. fir_data_in=0, shift_en=0. This clears the delay line. Then RUN.
//  RUN: s_ready=1, busy=0. Handshake -> fir_data_in=s_data. No handshake -> fir_data_in=0 (bubble:
//   zero enters the delay line; host must stream without gaps for exact convolution).
//   cfg_valid in RUN: s_ready drops in the same cycle (combinational on cfg_valid). cfg_ready=0 that
//   cycle. Next state is COLLECT. A simultaneous s_valid is NOT accepted.
//  All fir_* drives come from registers (one-cycle registered stage). accepted-sample flag enters vpipe.
//  vpipe: FIR_LAT+1 deep valid shift register covering the drive register plus FIR_LAT.
//   m_valid = tail of vpipe; m_data <= fir_data_out when tail set, else holds its value.
//   vpipe keeps shifting in all states, so outputs for accepted samples still emerge after leaving
//   RUN. No backpressure on m_*; the output cannot stall.
//  Outside RUN fir_data_in=0. fir_coef_shift_en=1 only in SHIFT. cfg_valid outside COLLECT/RUN waits.
//  Latency: sample handshake at cycle t -> m_valid at t+FIR_LAT+2.
//  Width rule: buf is ORDER x COEF_W. Counters are $clog2(ORDER+1) bits. No arithmetic beyond counters.
// TESTING (ORDER=6, FIR_LAT=1)
//  Reset then 6 cfg words of 1 -> cfg_ready low after 6th; shift_en high exactly 6 cycles.
//   Then 6 FLUSH cycles, then s_ready=1 and busy=0.
//  All-ones coefs, stream 5,0,0,0,0,0,0 -> m_valid 3 cycles after first handshake; m_data=5 x6, then 0.
//  Coefs 1,2,3,4,5,6, stream 1 then zeros -> the 6 outputs are the coefficients in tap order.
//   Reversing the write order reverses the output order.
//  cfg_valid in RUN with s_valid=1 same cycle -> that sample not accepted; pending outputs still emerge.
//   WAIT_DRAIN holds until the last m_valid; SHIFT then starts.
//  Reset asserted in SHIFT cycle 3 -> next cycle shift_en=0, COLLECT, coef_cnt=0, m_valid=0.
//  s_valid gaps in RUN (1,-,1) -> zero bubble in the delay line; output equals conv of (1,0,1).

Source files
------------

// File: rtl/fir_coef_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coef_seq_ctrl
//
// Sequencer placed in front of a DW_fir instance with ORDER taps. It collects
// one coefficient set from the config port. It waits until every accepted
// sample has left the filter. It then shifts the set into the filter and
// flushes the delay line with zeros. After that it streams samples through,
// and each filter output is tagged as valid.
//
// Ports
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   cfg_valid/ready     coefficient handshake; cfg_coef is in DW_fir shift-in order
//   cfg_coef            coefficient word
//   s_valid/ready       input sample handshake (s_ready only in RUN)
//   s_data              input sample
//   m_valid, m_data     registered filter output for each accepted sample
//   busy                high in every state except RUN
//   fir_coef_shift_en   DW_fir coef_shift_en (high only while shifting a set in)
//   fir_coef_in         DW_fir coef_in
//   fir_tc              DW_fir tc, tied to TC
//   fir_data_in         DW_fir data_in (zero whenever no sample is accepted)
//   fir_init_acc_val    DW_fir init_acc_val, tied to zero
//   fir_data_out        DW_fir data_out
// ---------------------------------------------------------------------------
module fir_coef_seq_ctrl #(
    parameter int DATA_IN_W  = 8,
    parameter int COEF_W     = 8,
    parameter int DATA_OUT_W = 18,
    parameter int ORDER      = 6,
    parameter int FIR_LAT    = 1,
    parameter bit TC         = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [COEF_W-1:0]     cfg_coef,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_IN_W-1:0]  s_data,
    output logic                  m_valid,
    output logic [DATA_OUT_W-1:0] m_data,
    output logic                  busy,
    output logic                  fir_coef_shift_en,
    output logic [COEF_W-1:0]     fir_coef_in,
    output logic                  fir_tc,
    output logic [DATA_IN_W-1:0]  fir_data_in,
    output logic [DATA_OUT_W-1:0] fir_init_acc_val,
    input  logic [DATA_OUT_W-1:0] fir_data_out
);

    localparam int                CNT_W = $clog2(ORDER + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(ORDER - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_WAIT_DRAIN,
        S_SHIFT,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        coef_cnt_q;
    logic [CNT_W-1:0]        step_cnt_q;
    logic [CNT_W-1:0]        step_cnt_d;
    logic [COEF_W-1:0]       coef_buf_q [ORDER];

    logic                    cfg_ready_q;
    logic                    shift_en_q;
    logic [COEF_W-1:0]       coef_in_q;
    logic [DATA_IN_W-1:0]    data_in_q;
    logic [FIR_LAT:0]        vpipe_q;
    logic                    m_valid_q;
    logic [DATA_OUT_W-1:0]   m_data_q;

    logic                    cfg_hs;
    logic                    s_hs;

    // A pending cfg_valid in RUN blocks the sample in the same cycle, so the
    // switch back to COLLECT never races with a sample handshake.
    assign s_ready    = (state_q == S_RUN) && !cfg_valid;
    assign s_hs       = s_valid && s_ready;
    assign cfg_hs     = cfg_valid && cfg_ready_q;
    assign step_cnt_d = step_cnt_q + 1'b1;

    // Coefficient buffer: data only, no reset. A partial set left by a reset
    // is simply overwritten, because coef_cnt restarts at zero.
    always_ff @(posedge clk) begin
        if (cfg_hs) begin
            coef_buf_q[coef_cnt_q] <= cfg_coef;
        end
    end

    // Stage p0 -> p1: sequencing FSM and the drive registers toward DW_fir.
    // vpipe follows an accepted sample through the drive register and the
    // FIR_LAT filter stages. m_data captures fir_data_out when vpipe has
    // reached its tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            coef_cnt_q  <= '0;
            step_cnt_q  <= '0;
            cfg_ready_q <= 1'b1;
            shift_en_q  <= 1'b0;
            coef_in_q   <= '0;
            data_in_q   <= '0;
            vpipe_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            // The valid pipe keeps running in every state, so samples that
            // are already in flight still come out after the FSM leaves RUN.
            vpipe_q   <= {vpipe_q[FIR_LAT-1:0], s_hs};
            m_valid_q <= vpipe_q[FIR_LAT];
            if (vpipe_q[FIR_LAT]) begin
                m_data_q <= fir_data_out;
            end

            // A cycle without a handshake pushes a zero bubble into the filter.
            data_in_q <= s_hs ? s_data : '0;

            case (state_q)
                S_COLLECT: begin
                    if (cfg_hs) begin
                        if (coef_cnt_q == LAST) begin
                            coef_cnt_q  <= '0;
                            cfg_ready_q <= 1'b0;
                            state_q     <= S_WAIT_DRAIN;
                        end else begin
                            coef_cnt_q <= coef_cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_DRAIN: begin
                    // The filter output for an in-flight sample would be
                    // corrupted by a coefficient shift, so wait for the pipe
                    // to empty.
                    if (vpipe_q == '0) begin
                        state_q    <= S_SHIFT;
                        step_cnt_q <= '0;
                        shift_en_q <= 1'b1;
                        coef_in_q  <= coef_buf_q[0];
                    end
                end
                S_SHIFT: begin
                    if (step_cnt_q == LAST) begin
                        state_q    <= S_FLUSH;
                        step_cnt_q <= '0;
                        shift_en_q <= 1'b0;
                        coef_in_q  <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_d;
                        coef_in_q  <= coef_buf_q[step_cnt_d];
                    end
                end
                S_FLUSH: begin
                    if (step_cnt_q == LAST) begin
                        state_q    <= S_RUN;
                        step_cnt_q <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_d;
                    end
                end
                S_RUN: begin
                    if (cfg_valid) begin
                        state_q     <= S_COLLECT;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    // Stage p1 -> outputs: every filter drive comes straight from a register.
    assign cfg_ready         = cfg_ready_q;
    assign busy              = (state_q != S_RUN);
    assign fir_coef_shift_en = shift_en_q;
    assign fir_coef_in       = coef_in_q;
    assign fir_data_in       = data_in_q;
    assign fir_tc            = TC;
    assign fir_init_acc_val  = '0;
    assign m_valid           = m_valid_q;
    assign m_data            = m_data_q;

endmodule
